// File: rtl/conv_encoder_stream.sv
// Streaming convolutional encoder with runtime K (3..MAX_K) and rate 1/N (N=2..MAX_N).
// Each frame is flushed with K-1 zero tail bits, so the trellis starts and ends in state 0.
module conv_encoder_stream #(
   parameter int MAX_K       = 9,
   parameter int MAX_N       = 3,
   parameter int FRAME_LEN_W = 12
) (
   input  logic                     sys_clk,
   input  logic                     rst,
   input  logic                     i_start,
   input  logic [3:0]               i_constr_len,
   input  logic [1:0]               i_code_rate,
   input  logic [MAX_N*MAX_K-1:0]   i_gen_poly,
   input  logic [FRAME_LEN_W-1:0]   i_frame_len,
   input  logic                     i_bit_valid,
   input  logic                     i_bit,
   output logic                     o_bit_ready,
   output logic                     o_sym_valid,
   output logic [MAX_N-1:0]         o_sym,
   output logic                     o_sym_last,
   input  logic                     i_sym_ready,
   output logic                     o_busy,
   output logic                     o_cfg_err
);

   // state    | meaning
   // S_IDLE   | waiting for i_start, config checked on start
   // S_DATA   | accepting frame data bits, one codeword per accepted bit
   // S_TAIL   | encoding K-1 zero tail bits, no input handshake
   // S_DRAIN  | final (last) codeword waiting for downstream acceptance
   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_TAIL,
      S_DRAIN
   } state_t;

   state_t                   state_q;
   logic [MAX_N*MAX_K-1:0]   poly_q;
   logic [FRAME_LEN_W-1:0]   bits_left_q;
   logic [3:0]               tail_left_q;
   logic [MAX_K-2:0]         sr_q;
   logic [MAX_N-1:0]         sym_q;
   logic                     sym_valid_q;
   logic                     sym_last_q;
   logic                     cfg_err_q;

   logic                     adv;
   logic                     accept;
   logic                     cfg_ok;
   logic                     in_bit;
   logic [MAX_K-1:0]         win;
   logic [MAX_K-1:0]         k_mask;
   logic [MAX_N*MAX_K-1:0]   poly_d;
   logic [MAX_N-1:0]         enc_d;
   logic [MAX_K-2:0]         sr_d;

   assign adv    = !sym_valid_q || i_sym_ready;
   assign accept = (state_q == S_DATA) && i_bit_valid && adv;
   assign cfg_ok = (int'(i_constr_len) >= 3) && (int'(i_constr_len) <= MAX_K) &&
                   (int'(i_code_rate) >= 2) && (int'(i_code_rate) <= MAX_N) &&
                   (i_frame_len != '0);

   // Taps at or above K and polynomials j>=N are zeroed when latched, so the
   // encoder below never needs K or N and stale high sr bits cannot leak out.
   always_comb begin
      k_mask = '0;
      poly_d = '0;
      for (int i = 0; i < MAX_K; i++) begin
         k_mask[i] = (i < int'(i_constr_len));
      end
      for (int j = 0; j < MAX_N; j++) begin
         if (j < int'(i_code_rate)) begin
            poly_d[j*MAX_K +: MAX_K] = i_gen_poly[j*MAX_K +: MAX_K] & k_mask;
         end
      end
   end

   always_comb begin
      in_bit = (state_q == S_DATA) ? i_bit : 1'b0;
      win    = {sr_q, in_bit};
      sr_d   = win[MAX_K-2:0];
      enc_d  = '0;
      for (int j = 0; j < MAX_N; j++) begin
         enc_d[j] = ^(poly_q[j*MAX_K +: MAX_K] & win);
      end
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         poly_q      <= '0;
         bits_left_q <= '0;
         tail_left_q <= '0;
         sr_q        <= '0;
         sym_q       <= '0;
         sym_valid_q <= 1'b0;
         sym_last_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         cfg_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  if (cfg_ok) begin
                     poly_q      <= poly_d;
                     bits_left_q <= i_frame_len;
                     tail_left_q <= i_constr_len - 4'd1;
                     sr_q        <= '0;
                     state_q     <= S_DATA;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (adv) begin
                  sym_valid_q <= accept;
                  if (accept) begin
                     sym_q       <= enc_d;
                     sr_q        <= sr_d;
                     bits_left_q <= bits_left_q - FRAME_LEN_W'(1);
                     if (bits_left_q == FRAME_LEN_W'(1)) begin
                        state_q <= S_TAIL;
                     end
                  end
               end
            end
            S_TAIL: begin
               if (adv) begin
                  sym_valid_q <= 1'b1;
                  sym_q       <= enc_d;
                  sr_q        <= sr_d;
                  tail_left_q <= tail_left_q - 4'd1;
                  if (tail_left_q == 4'd1) begin
                     sym_last_q <= 1'b1;
                     state_q    <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (sym_valid_q && i_sym_ready) begin
                  sym_valid_q <= 1'b0;
                  sym_last_q  <= 1'b0;
                  sr_q        <= '0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_bit_ready = (state_q == S_DATA) && adv;
   assign o_sym_valid = sym_valid_q;
   assign o_sym       = sym_q;
   assign o_sym_last  = sym_last_q;
   assign o_busy      = (state_q != S_IDLE);
   assign o_cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Bench for conv_encoder_stream: random frames against a convolution-sum reference model,
// with a queue scoreboard popped by an independent output monitor.
module tb_conv_encoder_stream;
   localparam int MAX_K = 9;
   localparam int MAX_N = 3;
   localparam int FLW   = 12;

   logic                   sys_clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   i_start = 1'b0;
   logic [3:0]             i_constr_len = '0;
   logic [1:0]             i_code_rate = '0;
   logic [MAX_N*MAX_K-1:0] i_gen_poly = '0;
   logic [FLW-1:0]         i_frame_len = '0;
   logic                   i_bit_valid = 1'b0;
   logic                   i_bit = 1'b0;
   logic                   i_sym_ready = 1'b1;
   logic                   o_bit_ready;
   logic                   o_sym_valid;
   logic [MAX_N-1:0]       o_sym;
   logic                   o_sym_last;
   logic                   o_busy;
   logic                   o_cfg_err;

   conv_encoder_stream #(.MAX_K(MAX_K), .MAX_N(MAX_N), .FRAME_LEN_W(FLW)) dut (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_constr_len (i_constr_len),
      .i_code_rate  (i_code_rate),
      .i_gen_poly   (i_gen_poly),
      .i_frame_len  (i_frame_len),
      .i_bit_valid  (i_bit_valid),
      .i_bit        (i_bit),
      .o_bit_ready  (o_bit_ready),
      .o_sym_valid  (o_sym_valid),
      .o_sym        (o_sym),
      .o_sym_last   (o_sym_last),
      .i_sym_ready  (i_sym_ready),
      .o_busy       (o_busy),
      .o_cfg_err    (o_cfg_err)
   );

   always #5 sys_clk = ~sys_clk;

   int         n_cmp = 0;
   int         n_err = 0;
   int         ready_mode = 0;
   logic [3:0] sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: codeword t, output j = XOR over taps i<K of g_j[i] * x[t-i],
   // with x = data followed by K-1 zeros and x[<0] = 0. Entry = {last, sym}.
   task automatic push_expect(input int k, input int n, input logic [MAX_N*MAX_K-1:0] poly,
                              input bit bits[$]);
      bit         seq[$];
      logic [3:0] e;
      bit         p;
      seq = bits;
      for (int i = 0; i < k - 1; i++) seq.push_back(1'b0);
      for (int t = 0; t < seq.size(); t++) begin
         e = '0;
         for (int j = 0; j < n; j++) begin
            p = 1'b0;
            for (int i = 0; i < k; i++) begin
               if (t - i >= 0) p = p ^ (poly[j*MAX_K + i] & seq[t-i]);
            end
            e[j] = p;
         end
         e[3] = (t == seq.size() - 1);
         sb.push_back(e);
      end
   endtask

   task automatic start_frame(input int k, input int n, input logic [MAX_N*MAX_K-1:0] poly,
                              input int len);
      i_start      = 1'b1;
      i_constr_len = 4'(k);
      i_code_rate  = 2'(n);
      i_gen_poly   = poly;
      i_frame_len  = FLW'(len);
      @(posedge sys_clk); #1;
      i_start      = 1'b0;
      i_constr_len = 4'($urandom);
      i_code_rate  = 2'($urandom);
      i_gen_poly   = {$urandom, $urandom};
      i_frame_len  = FLW'($urandom);
      check("busy_after_start", 32'(o_busy), 32'(1));
   endtask

   task automatic send_bits(input bit bits[$], input int count, input bit rand_valid);
      int idx;
      int guard;
      bit acc;
      idx = 0;
      guard = 0;
      while (idx < count && guard < 5000) begin
         i_bit_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
         i_bit       = bits[idx];
         @(negedge sys_clk);
         acc = i_bit_valid && o_bit_ready;
         @(posedge sys_clk); #1;
         if (acc) idx++;
         guard++;
      end
      i_bit_valid = 1'b0;
      check("bits_accepted", 32'(idx), 32'(count));
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      do begin
         @(posedge sys_clk); #1;
         g++;
      end while (o_busy && g < 3000);
      check("frame_done", 32'(o_busy), 32'(0));
   endtask

   task automatic run_frame(input int k, input int n, input logic [MAX_N*MAX_K-1:0] poly,
                            input bit bits[$], input bit rand_valid);
      push_expect(k, n, poly, bits);
      start_frame(k, n, poly, bits.size());
      send_bits(bits, bits.size(), rand_valid);
      wait_idle();
      check("sb_empty", 32'(sb.size()), 32'(0));
   endtask

   task automatic bad_start(input int k, input int n, input int len);
      i_start      = 1'b1;
      i_constr_len = 4'(k);
      i_code_rate  = 2'(n);
      i_gen_poly   = '1;
      i_frame_len  = FLW'(len);
      @(posedge sys_clk); #1;
      i_start = 1'b0;
      check("cfg_err_pulse", 32'(o_cfg_err), 32'(1));
      check("cfg_err_idle", 32'(o_busy), 32'(0));
      @(posedge sys_clk); #1;
      check("cfg_err_one_cycle", 32'(o_cfg_err), 32'(0));
      check("cfg_err_still_idle", 32'(o_busy), 32'(0));
   endtask

   function automatic bit [MAX_N*MAX_K-1:0] polys(input logic [8:0] g0, input logic [8:0] g1,
                                                  input logic [8:0] g2);
      return {g2, g1, g0};
   endfunction

   // Downstream ready pattern generator
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge sys_clk); #1;
         case (ready_mode)
            0:       i_sym_ready = 1'b1;
            1: begin
               i_sym_ready = (ph % 4 == 0) || (ph % 4 == 3);
               ph++;
            end
            default: i_sym_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // Output monitor / scoreboard
   initial begin
      logic [3:0] held;
      logic [3:0] exp;
      bit         hold;
      bit         chk_busy;
      hold = 1'b0;
      chk_busy = 1'b0;
      held = '0;
      forever begin
         @(negedge sys_clk);
         if (!rst) begin
            hold = 1'b0;
            chk_busy = 1'b0;
         end else begin
            if (chk_busy) begin
               check("busy_drop_after_last", 32'(o_busy), 32'(0));
               chk_busy = 1'b0;
            end
            if (hold) begin
               check("hold_valid", 32'(o_sym_valid), 32'(1));
               check("hold_sym", 32'({o_sym_last, o_sym}), 32'(held));
            end
            hold = 1'b0;
            if (o_sym_valid && !i_sym_ready) begin
               hold = 1'b1;
               held = {o_sym_last, o_sym};
               check("bit_ready_while_held", 32'(o_bit_ready), 32'(0));
            end
            if (o_sym_valid && i_sym_ready) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_sym: got 0x%0h, expected no codeword at t=%0t",
                           {o_sym_last, o_sym}, $time);
               end else begin
                  exp = sb.pop_front();
                  check("sym", 32'({o_sym_last, o_sym}), 32'(exp));
                  if (exp[3]) chk_busy = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bit                     b[$];
      bit [MAX_N*MAX_K-1:0]   p3;
      bit [MAX_N*MAX_K-1:0]   p9;

      p3 = polys(9'b000000111, 9'b000000101, 9'b000000000);
      p9 = polys(9'o557, 9'o663, 9'o711);

      rst = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_sym_valid", 32'(o_sym_valid), 32'(0));
      check("rst_sym", 32'(o_sym), 32'(0));
      check("rst_sym_last", 32'(o_sym_last), 32'(0));
      check("rst_bit_ready", 32'(o_bit_ready), 32'(0));
      check("rst_busy", 32'(o_busy), 32'(0));
      check("rst_cfg_err", 32'(o_cfg_err), 32'(0));
      @(negedge sys_clk);
      rst = 1'b1;
      @(posedge sys_clk); #1;

      // Directed K=3 frame, full-rate and then with stalls
      b = '{1'b1, 1'b0, 1'b1, 1'b1};
      ready_mode = 0;
      run_frame(3, 2, p3, b, 1'b0);
      ready_mode = 1;
      run_frame(3, 2, p3, b, 1'b0);

      ready_mode = 0;
      bad_start(2, 2, 4);
      bad_start(3, 1, 4);
      bad_start(3, 2, 0);

      // Maximum K, rate 1/3, random data and backpressure
      b.delete();
      for (int i = 0; i < 100; i++) b.push_back(bit'($urandom_range(0, 1)));
      ready_mode = 2;
      run_frame(9, 3, p9, b, 1'b1);

      // K=5 with taps above K set in every polynomial
      b.delete();
      for (int i = 0; i < 40; i++) b.push_back(bit'($urandom_range(0, 1)));
      run_frame(5, 3, p9, b, 1'b1);

      // Random K=4 rate 1/2, one-bit frame
      ready_mode = 0;
      b = '{1'b1};
      run_frame(4, 2, polys(9'($urandom), 9'($urandom), 9'($urandom)), b, 1'b0);

      // Reset asserted after two accepted data bits
      b = '{1'b1, 1'b1, 1'b0, 1'b1};
      push_expect(3, 2, p3, b);
      start_frame(3, 2, p3, 4);
      send_bits(b, 2, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_sym_valid", 32'(o_sym_valid), 32'(0));
      check("midrst_sym", 32'(o_sym), 32'(0));
      check("midrst_sym_last", 32'(o_sym_last), 32'(0));
      check("midrst_bit_ready", 32'(o_bit_ready), 32'(0));
      check("midrst_busy", 32'(o_busy), 32'(0));
      sb.delete();
      @(negedge sys_clk);
      rst = 1'b1;
      @(posedge sys_clk); #1;
      b = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      run_frame(3, 2, p3, b, 1'b0);

      // Back-to-back frames: second start lands the cycle after DRAIN exits
      b.delete();
      for (int i = 0; i < 12; i++) b.push_back(1'b1);
      run_frame(7, 3, p9, b, 1'b0);
      b = '{1'b1, 1'b0, 1'b1};
      run_frame(7, 3, p9, b, 1'b0);

      repeat (3) @(posedge sys_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
